// File: rtl/tr_reset_seq_if.sv
// Lane control/status bundle between the reset sequencer and the
// fPLL / 10GBASE-R wrapper it supervises.
`timescale 1ns/1ps

interface tr_reset_seq_if;
    logic       pll_locked;
    logic       pll_cal_busy;
    logic       rx_sync;
    logic       pll_powerdown;
    logic       tx_rst;
    logic       rx_rst;
    logic       tx_rdy;
    logic       rx_rdy;
    logic [2:0] state;
    logic [7:0] lock_fail_cnt;
    logic [7:0] sync_fail_cnt;

    modport master (
        input  pll_locked, pll_cal_busy, rx_sync,
        output pll_powerdown, tx_rst, rx_rst, tx_rdy, rx_rdy,
        output state, lock_fail_cnt, sync_fail_cnt
    );

    modport slave (
        output pll_locked, pll_cal_busy, rx_sync,
        input  pll_powerdown, tx_rst, rx_rst, tx_rdy, rx_rdy,
        input  state, lock_fail_cnt, sync_fail_cnt
    );
endinterface

// File: rtl/tr_reset_seq.sv
// 10GBASE-R lane bring-up/recovery sequencer: fPLL powerdown, lock,
// TX then RX PCS reset release, block-lock, with loss/timeout recovery.
`timescale 1ns/1ps

module tr_reset_seq #(
    parameter int PD_CYCLES    = 16,
    parameter int LOCK_FILTER  = 4,
    parameter int RST_HOLD     = 8,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int SYNC_TIMEOUT = 65536
) (
    input  logic           clk_glbl,
    input  logic           rst_glbl,
    tr_reset_seq_if.master lane
);
    typedef enum logic [2:0] {
        S_PD        = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_TX_RST    = 3'd2,
        S_RX_RST    = 3'd3,
        S_WAIT_SYNC = 3'd4,
        S_UP        = 3'd5
    } state_e;

    localparam int MAX_A = (PD_CYCLES > RST_HOLD) ? PD_CYCLES : RST_HOLD;
    localparam int MAX_B = (LOCK_TIMEOUT > SYNC_TIMEOUT) ?
                           LOCK_TIMEOUT : SYNC_TIMEOUT;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_C) + 1;
    localparam int FW    = $clog2(LOCK_FILTER) + 1;

    localparam logic [CW-1:0] PD_END   = CW'(PD_CYCLES - 1);
    localparam logic [CW-1:0] RST_END  = CW'(RST_HOLD - 1);
    localparam logic [CW-1:0] LOCK_END = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] SYNC_END = CW'(SYNC_TIMEOUT - 1);
    localparam logic [FW-1:0] FLT_MAX  = FW'(LOCK_FILTER);
    localparam logic [FW-1:0] FLT_END  = FW'(LOCK_FILTER - 1);

    logic [2:0]    meta_q, sync_q;
    logic          locked_s, busy_s, sync_s, lock_ok;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [FW-1:0] flt_q, flt_d;
    logic [7:0]    lock_fail_q, lock_fail_d;
    logic [7:0]    sync_fail_q, sync_fail_d;
    logic [4:0]    out_q, out_d;
    logic          qual, lock_inc, sync_inc;

    always_ff @(posedge clk_glbl or posedge rst_glbl) begin
        if (rst_glbl) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= {lane.pll_locked, lane.pll_cal_busy, lane.rx_sync};
            sync_q <= meta_q;
        end
    end

    assign locked_s = sync_q[2];
    assign busy_s   = sync_q[1];
    assign sync_s   = sync_q[0];
    assign lock_ok  = locked_s & ~busy_s;

    always_comb begin
        state_d  = state_q;
        qual     = 1'b0;
        lock_inc = 1'b0;
        sync_inc = 1'b0;
        unique case (state_q)
            S_PD: begin
                if (cnt_q == PD_END) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                qual = lock_ok;
                if (lock_ok && flt_q >= FLT_END) begin
                    state_d = S_TX_RST;
                end else if (cnt_q == LOCK_END) begin
                    state_d  = S_PD;
                    lock_inc = 1'b1;
                end
            end
            S_TX_RST: begin
                if (cnt_q == RST_END) state_d = S_RX_RST;
            end
            S_RX_RST: begin
                if (cnt_q == RST_END) state_d = S_WAIT_SYNC;
            end
            S_WAIT_SYNC: begin
                qual = sync_s;
                if (sync_s && flt_q >= FLT_END) begin
                    state_d = S_UP;
                end else if (cnt_q == SYNC_END) begin
                    state_d  = S_RX_RST;
                    sync_inc = 1'b1;
                end
            end
            S_UP: begin
                qual = ~sync_s;
                if (~sync_s && flt_q >= FLT_END) begin
                    state_d  = S_RX_RST;
                    sync_inc = 1'b1;
                end
            end
            default: state_d = S_PD;
        endcase

        // Lock loss overrides every other exit once past WAIT_LOCK
        if (!lock_ok && state_q inside {S_TX_RST, S_RX_RST,
                                        S_WAIT_SYNC, S_UP}) begin
            state_d  = S_PD;
            lock_inc = 1'b1;
            sync_inc = 1'b0;
        end

        if (state_d != state_q) begin
            cnt_d = '0;
            flt_d = '0;
        end else begin
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
            if (!qual)               flt_d = '0;
            else if (flt_q >= FLT_MAX) flt_d = flt_q;
            else                     flt_d = flt_q + 1'b1;
        end

        lock_fail_d = (lock_inc && lock_fail_q != 8'hFF) ?
                      lock_fail_q + 8'd1 : lock_fail_q;
        sync_fail_d = (sync_inc && sync_fail_q != 8'hFF) ?
                      sync_fail_q + 8'd1 : sync_fail_q;

        // {pll_powerdown, tx_rst, rx_rst, tx_rdy, rx_rdy} of next state
        unique case (state_d)
            S_PD:                  out_d = 5'b11100;
            S_WAIT_LOCK, S_TX_RST: out_d = 5'b01100;
            S_RX_RST:              out_d = 5'b00110;
            S_WAIT_SYNC:           out_d = 5'b00010;
            S_UP:                  out_d = 5'b00011;
            default:               out_d = 5'b11100;
        endcase
    end

    always_ff @(posedge clk_glbl or posedge rst_glbl) begin
        if (rst_glbl) begin
            state_q     <= S_PD;
            cnt_q       <= '0;
            flt_q       <= '0;
            lock_fail_q <= '0;
            sync_fail_q <= '0;
            out_q       <= 5'b11100;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            flt_q       <= flt_d;
            lock_fail_q <= lock_fail_d;
            sync_fail_q <= sync_fail_d;
            out_q       <= out_d;
        end
    end

    assign lane.pll_powerdown = out_q[4];
    assign lane.tx_rst        = out_q[3];
    assign lane.rx_rst        = out_q[2];
    assign lane.tx_rdy        = out_q[1];
    assign lane.rx_rdy        = out_q[0];
    assign lane.state         = state_q;
    assign lane.lock_fail_cnt = lock_fail_q;
    assign lane.sync_fail_cnt = sync_fail_q;
endmodule

// File: tb/tb_tr_reset_seq.sv
// Directed bench for tr_reset_seq: bring-up timing, lock/sync timeouts,
// filter glitches, lock loss, counter saturation and async reset.
`timescale 1ns/1ps

module tb_tr_reset_seq;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    tr_reset_seq_if lane ();

    tr_reset_seq #(
        .PD_CYCLES    (4),
        .LOCK_FILTER  (4),
        .RST_HOLD     (8),
        .LOCK_TIMEOUT (64),
        .SYNC_TIMEOUT (128)
    ) dut (
        .clk_glbl (clk),
        .rst_glbl (rst),
        .lane     (lane.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // Reset held over two edges; edge 1 is the first edge after release
    task automatic do_reset(input logic lk, input logic bz, input logic sy);
        rst               = 1'b1;
        lane.pll_locked   = lk;
        lane.pll_cal_busy = bz;
        lane.rx_sync      = sy;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, 32'(lane.state), 0);
        chk({tag, "_outs"},
            32'({lane.pll_powerdown, lane.tx_rst, lane.rx_rst,
                 lane.tx_rdy, lane.rx_rdy}), 32'b11100);
        chk({tag, "_lockf"}, 32'(lane.lock_fail_cnt), 0);
        chk({tag, "_syncf"}, 32'(lane.sync_fail_cnt), 0);
    endtask

    initial begin
        int pd_fall, tx_fall, rx_fall, rdy_rise, tx_hi;

        // Clean bring-up
        rst               = 1'b1;
        lane.pll_locked   = 1'b1;
        lane.pll_cal_busy = 1'b0;
        lane.rx_sync      = 1'b1;
        #12;
        chk_reset_vals("por");
        do_reset(1'b1, 1'b0, 1'b1);
        pd_fall = 0; tx_fall = 0; rx_fall = 0; rdy_rise = 0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk); #1;
            if (pd_fall == 0 && !lane.pll_powerdown) pd_fall = e;
            if (tx_fall == 0 && !lane.tx_rst)        tx_fall = e;
            if (rx_fall == 0 && !lane.rx_rst)        rx_fall = e;
            if (rdy_rise == 0 && lane.rx_rdy)        rdy_rise = e;
        end
        chk("up_pd_fall", pd_fall, 4);
        chk("up_tx_fall", tx_fall, 16);
        chk("up_rx_fall", rx_fall, 24);
        chk("up_rdy_rise", rdy_rise, 28);
        chk("up_state", 32'(lane.state), 5);
        chk("up_lockf", 32'(lane.lock_fail_cnt), 0);
        chk("up_syncf", 32'(lane.sync_fail_cnt), 0);

        // Lock timeout: PD/WAIT_LOCK period of 68
        do_reset(1'b0, 1'b0, 1'b1);
        tx_hi = 1;
        for (int e = 1; e <= 140; e++) begin
            @(posedge clk); #1;
            if (lane.tx_rst !== 1'b1) tx_hi = 0;
            if (e == 67) chk("lto_st67", 32'(lane.state), 1);
            if (e == 67) chk("lto_cnt67", 32'(lane.lock_fail_cnt), 0);
            if (e == 68) chk("lto_st68", 32'(lane.state), 0);
            if (e == 68) chk("lto_cnt68", 32'(lane.lock_fail_cnt), 1);
            if (e == 71) chk("lto_st71", 32'(lane.state), 0);
            if (e == 72) chk("lto_st72", 32'(lane.state), 1);
            if (e == 135) chk("lto_st135", 32'(lane.state), 1);
            if (e == 136) chk("lto_st136", 32'(lane.state), 0);
            if (e == 136) chk("lto_cnt136", 32'(lane.lock_fail_cnt), 2);
        end
        chk("lto_tx_held", tx_hi, 1);

        // Calibration busy, then a 2-cycle lock dropout in the filter
        do_reset(1'b1, 1'b1, 1'b1);
        for (int e = 1; e <= 44; e++) begin
            @(posedge clk); #1;
            if (e == 29) chk("cal_st29", 32'(lane.state), 1);
            if (e == 39) chk("cal_st39", 32'(lane.state), 1);
            if (e == 40) chk("cal_st40", 32'(lane.state), 2);
            if (e == 30) lane.pll_cal_busy = 1'b0;
            if (e == 32) lane.pll_locked = 1'b0;
            if (e == 34) lane.pll_locked = 1'b1;
        end
        chk("cal_lockf", 32'(lane.lock_fail_cnt), 0);

        // Sync timeout, then short and long sync dropouts while UP
        do_reset(1'b1, 1'b0, 1'b0);
        for (int e = 1; e <= 332; e++) begin
            @(posedge clk); #1;
            if (e == 151) chk("sto_st151", 32'(lane.state), 4);
            if (e == 152) chk("sto_st152", 32'(lane.state), 3);
            if (e == 152) chk("sto_cnt152", 32'(lane.sync_fail_cnt), 1);
            if (e == 287) chk("sto_st287", 32'(lane.state), 4);
            if (e == 288) chk("sto_st288", 32'(lane.state), 3);
            if (e == 288) chk("sto_cnt288", 32'(lane.sync_fail_cnt), 2);
            if (e == 288) chk("sto_tx288",
                              32'({lane.tx_rst, lane.tx_rdy}), 32'b01);
            if (e == 300) chk("sto_up300", 32'(lane.state), 5);
            if (e == 300) chk("sto_rdy300", 32'(lane.rx_rdy), 1);
            if (e == 310) chk("sto_glitch3", 32'(lane.state), 5);
            if (e == 317) chk("sto_st317", 32'(lane.state), 5);
            if (e == 318) chk("sto_loss4", 32'(lane.state), 3);
            if (e == 318) chk("sto_rdy318", 32'(lane.rx_rdy), 0);
            if (e == 318) chk("sto_cnt318", 32'(lane.sync_fail_cnt), 3);
            if (e == 330) chk("sto_reup", 32'(lane.state), 5);
            if (e == 288) lane.rx_sync = 1'b1;
            if (e == 302) lane.rx_sync = 1'b0;
            if (e == 305) lane.rx_sync = 1'b1;
            if (e == 312) lane.rx_sync = 1'b0;
            if (e == 316) lane.rx_sync = 1'b1;
        end
        chk("sto_lockf", 32'(lane.lock_fail_cnt), 0);

        // Single-cycle lock loss while UP
        do_reset(1'b1, 1'b0, 1'b1);
        for (int e = 1; e <= 36; e++) begin
            @(posedge clk); #1;
            if (e == 32) chk("ll_st32", 32'(lane.state), 5);
            if (e == 33) chk("ll_st33", 32'(lane.state), 0);
            if (e == 33) chk("ll_outs33",
                             32'({lane.pll_powerdown, lane.tx_rst,
                                  lane.rx_rst, lane.tx_rdy,
                                  lane.rx_rdy}), 32'b11100);
            if (e == 33) chk("ll_cnt33", 32'(lane.lock_fail_cnt), 1);
            if (e == 30) lane.pll_locked = 1'b0;
            if (e == 31) lane.pll_locked = 1'b1;
        end

        // 300 sync timeouts saturate the counter; then async reset
        do_reset(1'b1, 1'b0, 1'b0);
        for (int e = 1; e <= 40830; e++) begin
            @(posedge clk); #1;
            if (e == 34695) chk("sat_254", 32'(lane.sync_fail_cnt), 254);
            if (e == 34696) chk("sat_255", 32'(lane.sync_fail_cnt), 255);
            if (e == 40816) chk("sat_st", 32'(lane.state), 3);
            if (e == 40816) chk("sat_hold", 32'(lane.sync_fail_cnt), 255);
            if (e == 40830) chk("sat_ws", 32'(lane.state), 4);
        end
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("arst");
        #10;
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
